adc_acq_sequencer: RTL and testbench

ADC_ACQ_SEQUENCER -- requirements
Module: adc_acq_sequencer

---
 rtl/adc_acq_sequencer_pkg.sv | 7 +
 rtl/adc_acq_sequencer_if.sv | 9 +
 rtl/acq_down_counter.sv | 17 +
 rtl/adc_acq_sequencer.sv | 89 ++++++++
 tb/tb_adc_acq_sequencer.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/adc_acq_sequencer_pkg.sv
// adc_pkg: sequencer state encoding and ADC stream word layout (sample index above TS_LSB, sum below)
package adc_pkg;
  typedef enum logic [2:0] {IDLE, ARM, WAIT_TRIG, CAPTURE, HOLDOFF, DONE} state_t;
  localparam int ADC_TDATA_W = 64;
  localparam int TS_LSB = 15;
  localparam int TS_W = 49;
endpackage

// File: rtl/adc_acq_sequencer_if.sv
// adc_acq_sequencer_if: valid/data/last stream bundle; master drives tvalid/tdata/tlast, slave receives them
interface adc_acq_sequencer_if;
  import adc_pkg::*;
  logic tvalid;
  logic [ADC_TDATA_W-1:0] tdata;
  logic tlast;
  modport master(output tvalid, tdata, tlast);
  modport slave(input tvalid, tdata, tlast);
endinterface

// File: rtl/acq_down_counter.sv
// acq_down_counter: loadable down counter that stops at zero; ports clk, rst, load, load_val in, zero out
module acq_down_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] count;
  always_ff @(posedge clk)
    if (rst) count <= '0;
    else if (load) count <= load_val;
    else if (count != '0) count <= count - W'(1);
  assign zero = count == '0;
endmodule

// File: rtl/adc_acq_sequencer.sv
// adc_acq_sequencer: arms the ADC trigger, gates triggered bursts onto m_axis and sequences multi-shot runs
//   aclk/areset: clock, sync active-high reset; cfg_*: run control and shot shape
//   s_axis: ADC stream in (valid = trigger fired); m_axis: gated capture stream, one-cycle latency
//   reset_trigger/reset_max_sum: ADC resets; busy/done/irq/shot_count/trig_timestamp: run status
module adc_acq_sequencer
  import adc_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int ARM_CYCLES = 2
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                cfg_start,
  input  logic                cfg_abort,
  input  logic [CNT_W-1:0]    cfg_capture_len,
  input  logic [15:0]         cfg_holdoff,
  input  logic [15:0]         cfg_num_shots,
  input  logic                cfg_clear_max,
  adc_acq_sequencer_if.slave  s_axis,
  adc_acq_sequencer_if.master m_axis,
  output logic                reset_trigger,
  output logic                reset_max_sum,
  output logic                busy,
  output logic                done,
  output logic [15:0]         shot_count,
  output logic [TS_W-1:0]     trig_timestamp,
  output logic                irq
);
  localparam logic [CNT_W-1:0] ARM_LOAD = CNT_W'(ARM_CYCLES > 1 ? ARM_CYCLES - 1 : 0);
  state_t state, state_n;
  logic [CNT_W-1:0] beat, len_m1, cnt_val;
  logic [15:0] shot_inc;
  logic cnt_load, cnt_zero, accept, last, valid_q, tlast_q;
  logic [ADC_TDATA_W-1:0] tdata_q;
  assign len_m1 = cfg_capture_len == '0 ? '0 : cfg_capture_len - CNT_W'(1);
  assign shot_inc = shot_count == 16'hffff ? shot_count : shot_count + 16'd1;
  assign accept = s_axis.tvalid & (state == WAIT_TRIG | (state == CAPTURE & beat <= len_m1));
  assign last = state == WAIT_TRIG ? len_m1 == '0 : beat == len_m1;
  always_ff @(posedge aclk) state <= areset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE: state_n = cfg_start ? ARM : state;
      ARM:        state_n = cnt_zero ? WAIT_TRIG : ARM;
      WAIT_TRIG:  state_n = s_axis.tvalid ? CAPTURE : WAIT_TRIG;
      CAPTURE:    state_n = !s_axis.tvalid || beat >= len_m1 ? HOLDOFF : CAPTURE;
      HOLDOFF:    state_n = !cnt_zero ? HOLDOFF : cfg_num_shots != '0 && shot_inc == cfg_num_shots ? DONE : ARM;
      default:    state_n = IDLE;
    endcase
    if (cfg_abort) state_n = IDLE;
    cnt_load = state_n != state & (state_n == ARM | state_n == HOLDOFF);
    cnt_val = state_n == ARM ? ARM_LOAD : cfg_holdoff == '0 ? '0 : CNT_W'(cfg_holdoff - 16'd1);
    reset_trigger = !(state == WAIT_TRIG | state == CAPTURE);
    reset_max_sum = state == ARM & cfg_clear_max;
    busy = !(state == IDLE | state == DONE);
    done = state == DONE;
  end
  acq_down_counter #(.W(CNT_W)) u_cnt (
    .clk(aclk),
    .rst(areset | cfg_abort),
    .load(cnt_load),
    .load_val(cnt_val),
    .zero(cnt_zero)
  );
  always_ff @(posedge aclk)
    if (areset) begin
      valid_q <= 1'b0;
      tlast_q <= 1'b0;
      tdata_q <= '0;
      beat <= '0;
      shot_count <= '0;
      trig_timestamp <= '0;
      irq <= 1'b0;
    end else begin
      valid_q <= accept & ~cfg_abort;
      tlast_q <= accept & ~cfg_abort & last;
      tdata_q <= s_axis.tdata;
      irq <= state_n == DONE & state != DONE;
      beat <= cfg_abort ? '0 : !accept ? beat : state == WAIT_TRIG ? CNT_W'(1) : beat + CNT_W'(1);
      if (state == WAIT_TRIG & s_axis.tvalid & ~cfg_abort) trig_timestamp <= s_axis.tdata[ADC_TDATA_W-1:TS_LSB];
      if (!cfg_abort)
        shot_count <= (state == IDLE | state == DONE) & cfg_start ? '0 : state == HOLDOFF & cnt_zero ? shot_inc : shot_count;
    end
  assign m_axis.tvalid = valid_q;
  assign m_axis.tdata = tdata_q;
  // An early ADC drop is only visible the cycle the previous beat is already on the output,
  // so that beat's tlast is completed combinationally from the drop.
  assign m_axis.tlast = tlast_q | (valid_q & state == CAPTURE & ~s_axis.tvalid & ~cfg_abort & ~areset);
endmodule

// File: tb/tb_adc_acq_sequencer.sv
// tb_adc_acq_sequencer: randomized ADC bursts checked against shot-level expectations
module tb_adc_acq_sequencer;
  import adc_pkg::*;
  localparam int ARM_CYCLES = 2;
  logic aclk = 0, areset = 1, cfg_start = 0, cfg_abort = 0, cfg_clear_max = 0;
  logic [31:0] cfg_capture_len = 0;
  logic [15:0] cfg_holdoff = 0, cfg_num_shots = 0;
  logic reset_trigger, reset_max_sum, busy, done, irq;
  logic [15:0] shot_count;
  logic [48:0] trig_timestamp;
  adc_acq_sequencer_if s_if();
  adc_acq_sequencer_if m_if();
  adc_acq_sequencer #(.CNT_W(32), .ARM_CYCLES(ARM_CYCLES)) dut (
    .aclk(aclk), .areset(areset), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_capture_len(cfg_capture_len), .cfg_holdoff(cfg_holdoff), .cfg_num_shots(cfg_num_shots),
    .cfg_clear_max(cfg_clear_max), .s_axis(s_if), .m_axis(m_if), .reset_trigger(reset_trigger),
    .reset_max_sum(reset_max_sum), .busy(busy), .done(done), .shot_count(shot_count),
    .trig_timestamp(trig_timestamp), .irq(irq)
  );
  always #5 aclk = ~aclk;
  int checks = 0, failures = 0;
  int win_cnt, exp_total, beats_got, tlast_cnt, irq_cnt, rms_cnt, hi_run, out_idx, shot_exp;
  int cur_b, cur_d, ph, sent, len_eff, gap_exp, b_lo, b_hi, abort_win, abort_beat;
  bit drv_en, mon_en, use_rst, mid_start, in_win, kill_prev, post_abort, drv_rst, drv_start;
  logic [48:0] idx_next = 49'h100, ts_exp = 0;
  logic [63:0] words[$];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // ADC model: held off while reset_trigger is high; once released it waits a few cycles,
  // then streams a burst of cur_b consecutive sample words.
  initial begin : adc
    logic [63:0] word;
    bit kill;
    s_if.tvalid = 0;
    s_if.tdata = 0;
    s_if.tlast = 0;
    forever begin
      @(posedge aclk);
      #1;
      if (kill_prev) begin post_abort = 1; kill_prev = 0; end
      cfg_abort = 0;
      if (drv_rst) begin areset = 0; drv_rst = 0; end
      if (drv_start) begin cfg_start = 0; drv_start = 0; end
      if (!drv_en) s_if.tvalid = 0;
      else if (reset_trigger) begin
        in_win = 0;
        hi_run++;
        s_if.tvalid = 0;
      end else begin
        if (!in_win) begin
          in_win = 1;
          if (win_cnt > 0) chk("gap", hi_run, gap_exp);
          chk("shot_cnt_at_window", shot_count, win_cnt);
          win_cnt++;
          hi_run = 0;
          cur_b = $urandom_range(b_hi, b_lo);
          cur_d = $urandom_range(3, 0);
          ph = 0;
          sent = 0;
          words.delete();
          out_idx = 0;
          shot_exp = cur_b < len_eff ? cur_b : len_eff;
          exp_total += win_cnt == abort_win ? abort_beat - 1 : shot_exp;
        end
        if (ph >= cur_d && sent < cur_b) begin
          word = {idx_next, 15'($urandom)};
          idx_next++;
          s_if.tvalid = 1;
          s_if.tdata = word;
          words.push_back(word);
          kill = win_cnt == abort_win && sent == abort_beat - 1;
          if (kill) begin
            if (use_rst) begin areset = 1; drv_rst = 1; end
            else cfg_abort = 1;
            kill_prev = 1;
          end
          if (sent == 0 && !kill) ts_exp = word[63:15];
          if (mid_start && sent == 2) begin cfg_start = 1; drv_start = 1; end
          sent++;
        end else s_if.tvalid = 0;
        ph++;
      end
    end
  end
  initial begin : mon
    forever begin
      @(negedge aclk);
      if (mon_en) begin
        if (post_abort) begin
          chk("kill_tvalid", m_if.tvalid, 0);
          post_abort = 0;
        end
        if (m_if.tvalid) begin
          chk("beat_in_window", out_idx < words.size(), 1);
          if (out_idx < words.size()) chk("tdata", m_if.tdata, words[out_idx]);
          chk("tlast", m_if.tlast, out_idx == shot_exp - 1);
          beats_got++;
          tlast_cnt += int'(m_if.tlast);
          out_idx++;
        end else chk("tlast_idle", m_if.tlast, 0);
        irq_cnt += int'(irq);
        rms_cnt += int'(reset_max_sum);
      end
    end
  end
  task automatic do_run(input int len, shots, hold, cm, blo, bhi, aw, ab, rk, ms);
    int exp_win;
    bit hit;
    cfg_capture_len = len;
    cfg_num_shots = 16'(shots);
    cfg_holdoff = 16'(hold);
    cfg_clear_max = cm[0];
    len_eff = len == 0 ? 1 : len;
    gap_exp = (hold == 0 ? 1 : hold) + ARM_CYCLES;
    b_lo = blo;
    b_hi = bhi;
    abort_win = aw;
    abort_beat = ab;
    use_rst = rk[0];
    mid_start = ms[0];
    win_cnt = 0;
    exp_total = 0;
    beats_got = 0;
    tlast_cnt = 0;
    irq_cnt = 0;
    rms_cnt = 0;
    @(posedge aclk);
    #1 cfg_start = 1;
    @(posedge aclk);
    #1 cfg_start = 0;
    hit = 0;
    for (int c = 0; c < 5000 && !hit; c++) begin
      @(negedge aclk);
      hit = done || (aw != 0 && !busy);
    end
    chk("run_end", hit, 1);
    repeat (2) @(negedge aclk);
    exp_win = aw != 0 ? aw : shots;
    chk("windows", win_cnt, exp_win);
    chk("beats", beats_got, exp_total);
    chk("tlasts", tlast_cnt, aw != 0 ? aw - 1 : shots);
    chk("shot_count", shot_count, aw == 0 ? shots : rk != 0 ? 0 : aw - 1);
    chk("done", done, aw == 0);
    chk("busy", busy, 0);
    chk("irq", irq_cnt, aw == 0);
    chk("reset_max_sum_cycles", rms_cnt, cm != 0 ? ARM_CYCLES * exp_win : 0);
    chk("ts", trig_timestamp, rk != 0 ? 0 : ts_exp);
  endtask
  initial begin
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_reset_trigger", reset_trigger, 1);
    chk("rst_reset_max_sum", reset_max_sum, 0);
    chk("rst_tvalid", m_if.tvalid, 0);
    chk("rst_tlast", m_if.tlast, 0);
    chk("rst_tdata", m_if.tdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_irq", irq, 0);
    chk("rst_shot_count", shot_count, 0);
    chk("rst_ts", trig_timestamp, 0);
    @(posedge aclk);
    #1 areset = 0;
    drv_en = 1;
    mon_en = 1;
    do_run(4, 1, 0, 0, 10, 10, 0, 0, 0, 0);
    do_run(8, 3, 5, 1, 12, 12, 0, 0, 0, 0);
    do_run(100, 1, 2, 0, 20, 20, 0, 0, 0, 0);
    idx_next = 49'h1234;
    do_run(6, 1, 1, 0, 8, 8, 0, 0, 0, 1);
    chk("ts_1234", trig_timestamp, 49'h1234);
    do_run(8, 3, 2, 1, 20, 20, 2, 3, 0, 0);
    do_run(3, 0, 1, 1, 1, 6, 5, 1, 0, 0);
    for (int i = 0; i < 10; i++)
      do_run($urandom_range(10, 0), $urandom_range(3, 1), $urandom_range(5, 0),
             $urandom_range(1, 0), 1, 14, 0, 0, 0, 0);
    do_run(8, 2, 1, 1, 20, 20, 1, 3, 1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
